// File: rtl/uart_core_cfg.sv
// Full-duplex UART core with runtime baud divisor, 16x oversampled receiver,
// configurable frame format and internal TX->RX loopback.
module uart_core_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 loopback,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam logic [2:0] BIDX_LAST = 3'(DATA_BITS - 1);
  localparam logic       SCNT_LAST = 1'(STOP_BITS - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic                 tick16;
  logic [2:0]           tx_state;
  logic [3:0]           tx_tcnt;
  logic [2:0]           tx_bidx;
  logic                 tx_scnt;
  logic                 tx_line;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_accept;
  logic                 tx_bit_end;
  logic                 rx_sync_p0;
  logic                 rx_sync_p1;
  logic [2:0]           rx_state;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_bidx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 rx_par_exp;
  logic                 rx_bit_end;

  // >= rather than == so a divisor lowered mid-count restarts instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    div_cnt <= '0;
    else if (div_cnt >= baud_div) div_cnt <= '0;
    else                          div_cnt <= div_cnt + DIV_W'(1);
  end
  assign tick16 = (div_cnt == baud_div);

  assign tx_ready   = (tx_state == S_IDLE);
  assign tx_busy    = (tx_state != S_IDLE);
  assign tx         = tx_line;
  assign tx_accept  = tx_valid && tx_ready;
  assign tx_bit_end = tick16 && (tx_tcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (tx_accept) begin
      tx_shift <= tx_data;
      tx_par   <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
    end else if ((tx_state == S_DATA) && tx_bit_end) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // tx_line is registered so the pin never glitches on state decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_tcnt  <= '0;
      tx_bidx  <= '0;
      tx_scnt  <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      if ((tx_state != S_IDLE) && tick16) tx_tcnt <= tx_tcnt + 4'd1;
      case (tx_state)
        S_IDLE: if (tx_valid) begin
          tx_state <= S_START;
          tx_tcnt  <= '0;
          tx_line  <= 1'b0;
        end
        S_START: if (tx_bit_end) begin
          tx_state <= S_DATA;
          tx_bidx  <= '0;
          tx_line  <= tx_shift[0];
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_bidx == BIDX_LAST) begin
            if (PARITY_EN != 0) begin
              tx_state <= S_PARITY;
              tx_line  <= tx_par;
            end else begin
              tx_state <= S_STOP;
              tx_line  <= 1'b1;
              tx_scnt  <= 1'b0;
            end
          end else begin
            tx_bidx <= tx_bidx + 3'd1;
            tx_line <= tx_shift[1];
          end
        end
        S_PARITY: if (tx_bit_end) begin
          tx_state <= S_STOP;
          tx_line  <= 1'b1;
          tx_scnt  <= 1'b0;
        end
        S_STOP: if (tx_bit_end) begin
          if (tx_scnt == SCNT_LAST) tx_state <= S_IDLE;
          else                      tx_scnt  <= 1'b1;
        end
        default: begin
          tx_state <= S_IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  // Stage p0/p1: two-flop synchroniser, line idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= loopback ? tx_line : rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_bit_end = tick16 && (rx_tcnt == 4'd15);
  assign rx_par_exp = (PARITY_ODD != 0) ? ~^rx_shift : ^rx_shift;

  always_ff @(posedge clk) begin
    if ((rx_state == S_DATA) && rx_bit_end)   rx_shift   <= {rx_sync_p1, rx_shift[DATA_BITS-1:1]};
    if ((rx_state == S_PARITY) && rx_bit_end) rx_par_bit <= rx_sync_p1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= S_IDLE;
      rx_tcnt    <= '0;
      rx_bidx    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if ((rx_state != S_IDLE) && (rx_state != S_BREAK) && tick16) rx_tcnt <= rx_tcnt + 4'd1;
      case (rx_state)
        S_IDLE: if (!rx_sync_p1) begin
          rx_state <= S_START;
          rx_tcnt  <= '0;
        end
        S_START: if (tick16 && (rx_tcnt == 4'd7)) begin
          rx_tcnt  <= '0;
          rx_bidx  <= '0;
          rx_state <= rx_sync_p1 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_bit_end) begin
          if (rx_bidx == BIDX_LAST) rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else                      rx_bidx  <= rx_bidx + 3'd1;
        end
        S_PARITY: if (rx_bit_end) rx_state <= S_STOP;
        S_STOP: if (rx_bit_end) begin
          rx_data    <= rx_shift;
          parity_err <= (PARITY_EN != 0) && (rx_par_bit != rx_par_exp);
          frame_err  <= !rx_sync_p1;
          rx_valid   <= 1'b1;
          rx_state   <= rx_sync_p1 ? S_IDLE : S_BREAK;
        end
        // A held-low line must go high before another start bit is accepted
        S_BREAK: if (rx_sync_p1) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule
